// File: rtl/eth_vlg_sess_ctl.sv
// Session sequencer for the eth_vlg core: DHCP once per enable, then connect/listen with timeout,
// retry backoff and bounded failure. Define ETH_VLG_SESS_BACKOFF_EN for exponential backoff.
module eth_vlg_sess_ctl #(
  parameter int unsigned CONNECT_TIMEOUT   = 125000000,
  parameter int unsigned RETRY_DELAY       = 1250000,
  parameter int unsigned MAX_RETRIES       = 8,
  parameter int unsigned BACKOFF_MAX_SHIFT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        server_i,
  input  logic [31:0] cfg_rem_ipv4_i,
  input  logic [15:0] cfg_rem_port_i,
  input  logic [15:0] cfg_loc_port_i,
  input  logic        ready_i,
  input  logic        dhcp_success_i,
  input  logic        dhcp_fail_i,
  input  logic        idle_i,
  input  logic        listening_i,
  input  logic        connected_i,
  output logic        dhcp_start_o,
  output logic        connect_o,
  output logic        listen_o,
  output logic [31:0] rem_ipv4_o,
  output logic [15:0] rem_port_o,
  output logic [15:0] loc_port_o,
  output logic        up_o,
  output logic        fail_o,
  output logic [3:0]  state_o,
  output logic [7:0]  retries_o
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DHCP      = 4'd1;
  localparam logic [3:0] ST_ARM       = 4'd2;
  localparam logic [3:0] ST_WAIT_CONN = 4'd3;
  localparam logic [3:0] ST_UP        = 4'd4;
  localparam logic [3:0] ST_DROP      = 4'd5;
  localparam logic [3:0] ST_BACKOFF   = 4'd6;
  localparam logic [3:0] ST_FAIL      = 4'd7;
  localparam logic [3:0] ST_CLOSE     = 4'd8;

  localparam logic [31:0] CT_LAST   = CONNECT_TIMEOUT - 32'd1;
  localparam logic [31:0] RD_W      = RETRY_DELAY;
  localparam logic [31:0] MAX_RET_W = MAX_RETRIES;

  logic [3:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  retries_q, retries_d, retries_inc;
  logic        dhcp_start_q, dhcp_start_d;
  logic        connect_q, connect_d;
  logic        listen_q, listen_d;
  logic        up_q, up_d;
  logic        fail_q, fail_d;
  logic [31:0] rem_ipv4_q, rem_ipv4_d;
  logic [15:0] rem_port_q, rem_port_d;
  logic [15:0] loc_port_q, loc_port_d;
  logic [31:0] backoff_delay;
  logic        sess_hold;

  // These core status pins are not needed for sequencing.
  logic unused_status;
  assign unused_status = ^{dhcp_success_i, dhcp_fail_i, listening_i};

`ifdef ETH_VLG_SESS_BACKOFF_EN
  logic [31:0] shift_amt;
  logic [63:0] delay_wide;
  logic        delay_sat;

  always_comb begin
    shift_amt = (retries_q == 8'd0) ? 32'd0 : {24'd0, retries_q - 8'd1};
    if (shift_amt > BACKOFF_MAX_SHIFT) shift_amt = BACKOFF_MAX_SHIFT;
    delay_wide = {32'd0, RD_W} << shift_amt;
    // Shifts past 32 lose bits off the wide word, so saturate on the operand instead.
    if (shift_amt > 32'd32) delay_sat = (RD_W != 32'd0);
    else                    delay_sat = |delay_wide[63:32];
    backoff_delay = delay_sat ? 32'hFFFF_FFFF : delay_wide[31:0];
  end
`else
  localparam logic [31:0] BMS_UNUSED = BACKOFF_MAX_SHIFT;
  assign backoff_delay = RD_W;
`endif

  assign retries_inc = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
    retries_d = retries_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_DHCP;
      ST_DHCP: if (ready_i) state_d = ST_ARM;
      ST_ARM: begin
        state_d = ST_WAIT_CONN;
        timer_d = 32'd0;
      end
      ST_WAIT_CONN: begin
        if (connected_i) begin
          state_d   = ST_UP;
          retries_d = 8'd0;
        end else if (!listen_q && timer_q == CT_LAST) begin
          state_d   = ST_DROP;
          retries_d = retries_inc;
        end
      end
      ST_UP: begin
        if (!connected_i) begin
          state_d   = ST_DROP;
          retries_d = retries_inc;
        end
      end
      ST_DROP: begin
        if (idle_i) begin
          if (MAX_RET_W != 32'd0 && {24'd0, retries_q} >= MAX_RET_W) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_BACKOFF;
            timer_d = 32'd0;
          end
        end
      end
      ST_BACKOFF: if (timer_q == backoff_delay - 32'd1) state_d = ST_ARM;
      ST_FAIL:    if (!en_i) state_d = ST_IDLE;
      ST_CLOSE:   if (idle_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Tear-down overrides whatever the session was about to do this cycle.
    if (!en_i && state_q != ST_IDLE && state_q != ST_FAIL && state_q != ST_CLOSE) begin
      state_d   = ST_CLOSE;
      retries_d = retries_q;
    end
    if (state_d == ST_IDLE) retries_d = 8'd0;

    sess_hold    = (state_d == ST_WAIT_CONN) || (state_d == ST_UP);
    dhcp_start_d = (state_q == ST_DHCP) && (state_d == ST_DHCP);
    connect_d    = 1'b0;
    listen_d     = 1'b0;
    if (sess_hold) begin
      if (state_q == ST_ARM) begin
        connect_d = !server_i;
        listen_d  = server_i;
      end else begin
        connect_d = connect_q;
        listen_d  = listen_q;
      end
    end
    up_d   = (state_q == ST_UP) && (state_d == ST_UP);
    fail_d = (state_d == ST_FAIL);

    rem_ipv4_d = rem_ipv4_q;
    rem_port_d = rem_port_q;
    loc_port_d = loc_port_q;
    if (state_q == ST_ARM) begin
      rem_ipv4_d = cfg_rem_ipv4_i;
      rem_port_d = cfg_rem_port_i;
      loc_port_d = cfg_loc_port_i;
    end
    if (state_d == ST_IDLE) begin
      rem_ipv4_d = 32'd0;
      rem_port_d = 16'd0;
      loc_port_d = 16'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      timer_q      <= 32'd0;
      retries_q    <= 8'd0;
      dhcp_start_q <= 1'b0;
      connect_q    <= 1'b0;
      listen_q     <= 1'b0;
      up_q         <= 1'b0;
      fail_q       <= 1'b0;
      rem_ipv4_q   <= 32'd0;
      rem_port_q   <= 16'd0;
      loc_port_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retries_q    <= retries_d;
      dhcp_start_q <= dhcp_start_d;
      connect_q    <= connect_d;
      listen_q     <= listen_d;
      up_q         <= up_d;
      fail_q       <= fail_d;
      rem_ipv4_q   <= rem_ipv4_d;
      rem_port_q   <= rem_port_d;
      loc_port_q   <= loc_port_d;
    end
  end

  assign dhcp_start_o = dhcp_start_q;
  assign connect_o    = connect_q;
  assign listen_o     = listen_q;
  assign up_o         = up_q;
  assign fail_o       = fail_q;
  assign rem_ipv4_o   = rem_ipv4_q;
  assign rem_port_o   = rem_port_q;
  assign loc_port_o   = loc_port_q;
  assign state_o      = state_q;
  assign retries_o    = retries_q;

endmodule

// File: tb/tb_eth_vlg_sess_ctl.sv
// Directed bench for eth_vlg_sess_ctl with CONNECT_TIMEOUT=100, RETRY_DELAY=20, MAX_RETRIES=3.
module tb_eth_vlg_sess_ctl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b0;
  logic        server_i = 1'b0;
  logic [31:0] cfg_rem_ipv4_i = 32'd0;
  logic [15:0] cfg_rem_port_i = 16'd0;
  logic [15:0] cfg_loc_port_i = 16'd0;
  logic        ready_i = 1'b0;
  logic        dhcp_success_i = 1'b0;
  logic        dhcp_fail_i = 1'b0;
  logic        idle_i = 1'b1;
  logic        listening_i = 1'b0;
  logic        connected_i = 1'b0;
  logic        dhcp_start_o, connect_o, listen_o, up_o, fail_o;
  logic [31:0] rem_ipv4_o;
  logic [15:0] rem_port_o, loc_port_o;
  logic [3:0]  state_o;
  logic [7:0]  retries_o;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  eth_vlg_sess_ctl #(
    .CONNECT_TIMEOUT(100),
    .RETRY_DELAY(20),
    .MAX_RETRIES(3),
    .BACKOFF_MAX_SHIFT(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .server_i(server_i),
    .cfg_rem_ipv4_i(cfg_rem_ipv4_i), .cfg_rem_port_i(cfg_rem_port_i),
    .cfg_loc_port_i(cfg_loc_port_i), .ready_i(ready_i),
    .dhcp_success_i(dhcp_success_i), .dhcp_fail_i(dhcp_fail_i),
    .idle_i(idle_i), .listening_i(listening_i), .connected_i(connected_i),
    .dhcp_start_o(dhcp_start_o), .connect_o(connect_o), .listen_o(listen_o),
    .rem_ipv4_o(rem_ipv4_o), .rem_port_o(rem_port_o), .loc_port_o(loc_port_o),
    .up_o(up_o), .fail_o(fail_o), .state_o(state_o), .retries_o(retries_o)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Waits until connect_o equals lvl; also counts cycles spent in BACKOFF on the way.
  task automatic wait_conn(input string tag, input logic lvl, input int budget,
                           output int at, output int bk);
    int left;
    left = budget;
    bk = 0;
    while (connect_o !== lvl && left > 0) begin
      if (state_o == 4'd6) bk++;
      step();
      left--;
    end
    if (connect_o !== lvl) check({tag, "_timeout"}, 32'd0, 32'd1);
    at = cyc;
  endtask

  initial begin
    int t_rise, t_fall, bk, bad, left;
    logic [31:0] ipv4;
    logic [15:0] lport;

    ipv4  = $urandom();
    lport = 16'($urandom_range(1024, 65535));
    cfg_rem_ipv4_i = ipv4;
    cfg_loc_port_i = lport;
    cfg_rem_port_i = 16'($urandom_range(1, 65535));

    // Reset state
    steps(3);
    check("rst_state", {28'd0, state_o}, 32'd0);
    check("rst_dhcp", {31'd0, dhcp_start_o}, 32'd0);
    check("rst_connect", {31'd0, connect_o}, 32'd0);
    check("rst_up_fail", {30'd0, up_o, fail_o}, 32'd0);
    check("rst_retries", {24'd0, retries_o}, 32'd0);
    check("rst_rem", rem_ipv4_o | {16'd0, rem_port_o} | {16'd0, loc_port_o}, 32'd0);
    rst_i = 1'b1;
    step();

    // Client bring-up: en at cycle 0, ready at 10, connected at 40
    exp_q.push_back({16'd0, cfg_rem_port_i});
    idle_i = 1'b0;
    en_i = 1'b1;
    step();
    check("bu_state_dhcp", {28'd0, state_o}, 32'd1);
    check("bu_dhcp_c1", {31'd0, dhcp_start_o}, 32'd0);
    step();
    check("bu_dhcp_c2", {31'd0, dhcp_start_o}, 32'd1);
    steps(8);
    check("bu_dhcp_c10", {31'd0, dhcp_start_o}, 32'd1);
    ready_i = 1'b1;
    step();
    check("bu_dhcp_c11", {31'd0, dhcp_start_o}, 32'd0);
    check("bu_state_arm", {28'd0, state_o}, 32'd2);
    check("bu_connect_c11", {31'd0, connect_o}, 32'd0);
    step();
    check("bu_connect_c12", {31'd0, connect_o}, 32'd1);
    check("bu_listen_c12", {31'd0, listen_o}, 32'd0);
    check("bu_rem_port", {16'd0, rem_port_o}, exp_q.pop_front());
    check("bu_rem_ipv4", rem_ipv4_o, ipv4);
    check("bu_loc_port", {16'd0, loc_port_o}, {16'd0, lport});
    steps(28);
    check("bu_up_c40", {31'd0, up_o}, 32'd0);
    connected_i = 1'b1;
    step();
    check("bu_state_up", {28'd0, state_o}, 32'd4);
    check("bu_up_c41", {31'd0, up_o}, 32'd0);
    step();
    check("bu_up_c42", {31'd0, up_o}, 32'd1);
    check("bu_retries", {24'd0, retries_o}, 32'd0);

    // Link drop with a retargeted remote port
    steps(5);
    cfg_rem_port_i = 16'd8080;
    exp_q.push_back(32'd8080);
    step();
    connected_i = 1'b0;
    step();
    check("ld_state_drop", {28'd0, state_o}, 32'd5);
    check("ld_up_low", {31'd0, up_o}, 32'd0);
    check("ld_connect_low", {31'd0, connect_o}, 32'd0);
    check("ld_retries", {24'd0, retries_o}, 32'd1);
    step();
    check("ld_wait_idle", {28'd0, state_o}, 32'd5);
    idle_i = 1'b1;
    step();
    check("ld_state_backoff", {28'd0, state_o}, 32'd6);
    steps(19);
    check("ld_backoff_end", {28'd0, state_o}, 32'd6);
    step();
    check("ld_state_arm", {28'd0, state_o}, 32'd2);
    step();
    check("ld_reconnect", {31'd0, connect_o}, 32'd1);
    check("ld_rem_port", {16'd0, rem_port_o}, exp_q.pop_front());
    connected_i = 1'b1;
    idle_i = 1'b0;
    step();
    check("ld_retries_clr", {24'd0, retries_o}, 32'd0);
    step();
    check("ld_up_again", {31'd0, up_o}, 32'd1);

    // Close from UP; en re-asserted during CLOSE is ignored
    en_i = 1'b0;
    step();
    check("cl_state_close", {28'd0, state_o}, 32'd8);
    check("cl_drive_low", {29'd0, connect_o, listen_o, up_o}, 32'd0);
    en_i = 1'b1;
    steps(2);
    check("cl_en_ignored", {28'd0, state_o}, 32'd8);
    en_i = 1'b0;
    idle_i = 1'b1;
    connected_i = 1'b0;
    step();
    check("cl_state_idle", {28'd0, state_o}, 32'd0);
    check("cl_rem_port_clr", {16'd0, rem_port_o}, 32'd0);

    // Timeout until failure: three 100-cycle attempts with backoffs between
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd100);
`ifdef ETH_VLG_SESS_BACKOFF_EN
    exp_q.push_back(32'd40);
`else
    exp_q.push_back(32'd20);
`endif
    exp_q.push_back(32'd100);
    en_i = 1'b1;
    wait_conn("to_first_rise", 1'b1, 50, t_rise, bk);
    for (int p = 0; p < 3; p++) begin
      wait_conn("to_fall", 1'b0, 300, t_fall, bk);
      check($sformatf("to_pulse_len%0d", p), t_fall - t_rise, exp_q.pop_front());
      if (p < 2) begin
        wait_conn("to_rise", 1'b1, 300, t_rise, bk);
        check($sformatf("to_backoff%0d", p), bk, exp_q.pop_front());
      end
    end
    check("to_retries", {24'd0, retries_o}, 32'd3);
    step();
    check("to_state_fail", {28'd0, state_o}, 32'd7);
    check("to_fail", {31'd0, fail_o}, 32'd1);
    steps(50);
    check("to_fail_held", {27'd0, state_o, connect_o}, 32'd14);
    en_i = 1'b0;
    step();
    check("to_back_idle", {28'd0, state_o}, 32'd0);
    check("to_fail_clr", {23'd0, fail_o, retries_o}, 32'd0);

    // Server: no timeout while listening
    server_i = 1'b1;
    en_i = 1'b1;
    left = 20;
    while (listen_o !== 1'b1 && left > 0) begin
      step();
      left--;
    end
    check("sv_listen_rise", {31'd0, listen_o}, 32'd1);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      if (listen_o !== 1'b1 || state_o != 4'd3 || connect_o !== 1'b0) bad++;
      step();
    end
    check("sv_no_timeout", bad, 32'd0);
    connected_i = 1'b1;
    steps(2);
    check("sv_up", {31'd0, up_o}, 32'd1);
    en_i = 1'b0;
    steps(2);
    check("sv_closed", {28'd0, state_o}, 32'd0);
    server_i = 1'b0;
    connected_i = 1'b0;

    // Tear-down in the same cycle the connect timeout expires
    en_i = 1'b1;
    wait_conn("td_rise", 1'b1, 50, t_rise, bk);
    steps(99);
    check("td_still_conn", {31'd0, connect_o}, 32'd1);
    en_i = 1'b0;
    step();
    check("td_state_close", {28'd0, state_o}, 32'd8);
    check("td_retries", {24'd0, retries_o}, 32'd0);
    check("td_connect_low", {31'd0, connect_o}, 32'd0);
    step();
    check("td_state_idle", {28'd0, state_o}, 32'd0);

    // Mid-session reset
    en_i = 1'b1;
    wait_conn("mr_rise", 1'b1, 50, t_rise, bk);
    steps(5);
    rst_i = 1'b0;
    step();
    check("mr_state", {28'd0, state_o}, 32'd0);
    check("mr_drive", {27'd0, dhcp_start_o, connect_o, listen_o, up_o, fail_o}, 32'd0);
    check("mr_rem", rem_ipv4_o | {16'd0, rem_port_o} | {16'd0, loc_port_o}, 32'd0);
    rst_i = 1'b1;
    en_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
